// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU results and buffered load returns onto the
// single register-file write port, with starvation guard and rd query.
// Ports: clk, rst_n; alu_valid/alu_ready/alu_rd/alu_data;
//        load_valid/load_ready/load_rd/load_data; q_rs/q_hit; rd/wr/wd.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module writeback_arbiter #(
    parameter int DATA_WIDTH   = `DATA_WIDTH,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4:0]            load_rd,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [4:0]            q_rs,
    output logic                  q_hit,
    output logic [4:0]            rd,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] wd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]            r_mem_rd   [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic [WW-1:0]         r_wait;
    logic [4:0]            r_rd;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_wd;

    logic w_empty;
    logic w_force;
    logic w_alu_win;
    logic w_pop;
    logic w_push;
    logic w_hit;

    assign w_empty    = (r_count == '0);
    assign load_ready = (r_count != CW'(DEPTH));
    assign w_force    = (r_wait == WW'(STARVE_LIMIT)) && !w_empty;
    assign alu_ready  = !w_force;
    assign w_alu_win  = !w_force && alu_valid && (alu_rd != 5'd0);
    // Head pops whenever the ALU does not take the slot (forced or not).
    assign w_pop      = !w_empty && !w_alu_win;
    // x0 loads complete the handshake but are never stored.
    assign w_push     = load_valid && load_ready && (load_rd != 5'd0);

    // Entry i is live when its distance from the read pointer is < count.
    always_comb begin
        logic [PW-1:0] w_off;
        w_hit = 1'b0;
        w_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_rptr;
            if (({1'b0, w_off} < r_count) && (r_mem_rd[i] == q_rs))
                w_hit = 1'b1;
        end
        q_hit = w_hit && (q_rs != 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_rd[i]   <= '0;
                r_mem_data[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_wait  <= '0;
            r_rd    <= '0;
            r_wr    <= 1'b0;
            r_wd    <= '0;
        end else begin
            if (w_push) begin
                r_mem_rd[r_wptr]   <= load_rd;
                r_mem_data[r_wptr] <= load_data;
                r_wptr             <= r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;

            if (w_empty || w_pop)
                r_wait <= '0;
            else if (r_wait != WW'(STARVE_LIMIT))
                r_wait <= r_wait + 1'b1;

            if (w_alu_win) begin
                r_wr <= 1'b1;
                r_rd <= alu_rd;
                r_wd <= alu_data;
            end else if (w_pop) begin
                r_wr <= 1'b1;
                r_rd <= r_mem_rd[r_rptr];
                r_wd <= r_mem_data[r_rptr];
            end else begin
                r_wr <= 1'b0;
            end
        end
    end

    assign rd = r_rd;
    assign wr = r_wr;
    assign wd = r_wd;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed scenario tasks for writeback_arbiter.
// Inputs change 1 time unit after the rising edge; outputs sampled then.
module tb_writeback_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        load_valid;
    logic        load_ready;
    logic [4:0]  load_rd;
    logic [31:0] load_data;
    logic [4:0]  q_rs;
    logic        q_hit;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] wd;

    int n_cmp = 0;
    int n_bad = 0;

    writeback_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_rd    (load_rd),
        .load_data  (load_data),
        .q_rs       (q_rs),
        .q_hit      (q_hit),
        .rd         (rd),
        .wr         (wr),
        .wd         (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid  = 1'b0;
        alu_rd     = '0;
        alu_data   = '0;
        load_valid = 1'b0;
        load_rd    = '0;
        load_data  = '0;
        q_rs       = '0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        alu_valid  = 1'b1;
        alu_rd     = 5'($urandom);
        alu_data   = $urandom;
        load_valid = 1'b1;
        load_rd    = 5'($urandom);
        load_data  = $urandom;
        q_rs       = 5'($urandom);
        step();
        step();
        n_cmp++;
        if ({wr, rd, wd} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_out wr=%b rd=%0d wd=%h want 0", wr, rd, wd);
        end
        n_cmp++;
        if ({load_ready, alu_ready, q_hit} !== 3'b110) begin
            n_bad++;
            $display("FAIL reset_hs lr=%b ar=%b qh=%b want 1 1 0",
                     load_ready, alu_ready, q_hit);
        end
        idle_inputs();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu_path();
        alu_valid = 1'b1;
        alu_rd    = 5'd6;
        alu_data  = 32'hAAAAAAAA;
        step();
        idle_inputs();
        n_cmp++;
        if ({wr, rd, wd} !== {1'b1, 5'd6, 32'hAAAAAAAA}) begin
            n_bad++;
            $display("FAIL alu_write wr=%b rd=%0d wd=%h want 1 6 aaaaaaaa",
                     wr, rd, wd);
        end
        step();
        n_cmp++;
        if (wr !== 1'b0) begin
            n_bad++;
            $display("FAIL alu_idle wr=%b want 0", wr);
        end
    endtask

    task automatic test_load_query();
        load_valid = 1'b1;
        load_rd    = 5'd3;
        load_data  = 32'h55555555;
        q_rs       = 5'd3;
        #1;
        n_cmp++;
        if (q_hit !== 1'b0) begin
            n_bad++;
            $display("FAIL q_same_cycle q_hit=%b want 0", q_hit);
        end
        step();
        load_valid = 1'b0;
        #1;
        n_cmp++;
        if ({q_hit, wr} !== 2'b10) begin
            n_bad++;
            $display("FAIL load_n1 q_hit=%b wr=%b want 1 0", q_hit, wr);
        end
        step();
        n_cmp++;
        if ({wr, rd, wd} !== {1'b1, 5'd3, 32'h55555555}) begin
            n_bad++;
            $display("FAIL load_write wr=%b rd=%0d wd=%h want 1 3 55555555",
                     wr, rd, wd);
        end
        n_cmp++;
        if (q_hit !== 1'b0) begin
            n_bad++;
            $display("FAIL q_after_pop q_hit=%b want 0", q_hit);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_x0_drop();
        alu_valid  = 1'b1;
        alu_rd     = 5'd1;
        alu_data   = 32'h11;
        load_valid = 1'b1;
        load_rd    = 5'd5;
        load_data  = 32'h1234;
        step();
        load_valid = 1'b0;
        alu_rd     = 5'd0;
        alu_data   = 32'hDEAD;
        #1;
        n_cmp++;
        if ({alu_ready, wr, rd} !== {1'b1, 1'b1, 5'd1}) begin
            n_bad++;
            $display("FAIL x0_pre ar=%b wr=%b rd=%0d want 1 1 1",
                     alu_ready, wr, rd);
        end
        step();
        alu_valid = 1'b0;
        n_cmp++;
        if ({wr, rd, wd} !== {1'b1, 5'd5, 32'h1234}) begin
            n_bad++;
            $display("FAIL x0_alu wr=%b rd=%0d wd=%h want 1 5 1234",
                     wr, rd, wd);
        end
        load_valid = 1'b1;
        load_rd    = 5'd0;
        load_data  = 32'h99;
        #1;
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL x0_load_ready lr=%b want 1", load_ready);
        end
        step();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (wr !== 1'b0) begin
                n_bad++;
                $display("FAIL x0_load_nowr c=%0d wr=%b want 0", c, wr);
            end
            step();
        end
    endtask

    task automatic test_full_fifo();
        logic [3:0] av;
        logic [5:0] lv;
        logic [9:0] elr;
        logic [4:0] erd [10];
        logic [31:0] ewd [10];
        int li;
        av  = 4'b1111;
        lv  = 6'b111111;
        elr = 10'b1111101111;
        erd = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd10, 5'd11, 5'd12, 5'd13,
                5'd14, 5'd0};
        ewd = '{32'h100, 32'h101, 32'h102, 32'h103, 32'hA0, 32'hA1,
                32'hA2, 32'hA3, 32'hA4, 32'h0};
        li  = 0;
        for (int c = 0; c < 10; c++) begin
            alu_valid  = (c < 4) ? av[c] : 1'b0;
            alu_rd     = 5'd1;
            alu_data   = 32'h100 + 32'(c);
            load_valid = (li < 5) ? lv[li] : 1'b0;
            load_rd    = 5'(10 + li);
            load_data  = 32'hA0 + 32'(li);
            q_rs       = 5'd13;
            #1;
            if (c < 6) begin
                n_cmp++;
                if (load_ready !== elr[c]) begin
                    n_bad++;
                    $display("FAIL full_lr c=%0d lr=%b want %b",
                             c, load_ready, elr[c]);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (q_hit !== 1'b1) begin
                    n_bad++;
                    $display("FAIL full_qhit q_hit=%b want 1", q_hit);
                end
            end
            if (load_valid && load_ready)
                li++;
            step();
            if (c < 9) begin
                n_cmp++;
                if ({wr, rd, wd} !== {1'b1, erd[c], ewd[c]}) begin
                    n_bad++;
                    $display("FAIL full_wr c=%0d wr=%b rd=%0d wd=%h want 1 %0d %h",
                             c, wr, rd, wd, erd[c], ewd[c]);
                end
            end else begin
                n_cmp++;
                if (wr !== 1'b0) begin
                    n_bad++;
                    $display("FAIL full_end wr=%b want 0", wr);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        for (int c = 0; c < 11; c++) begin
            alu_valid  = 1'b1;
            alu_rd     = 5'd2;
            alu_data   = 32'h200 + 32'(c);
            load_valid = (c == 0);
            load_rd    = 5'd7;
            load_data  = 32'h77;
            #1;
            n_cmp++;
            if (alu_ready !== (c != 9)) begin
                n_bad++;
                $display("FAIL starve_ar c=%0d ar=%b want %b",
                         c, alu_ready, (c != 9));
            end
            step();
            if (c == 9) begin
                n_cmp++;
                if ({wr, rd, wd} !== {1'b1, 5'd7, 32'h77}) begin
                    n_bad++;
                    $display("FAIL starve_drain wr=%b rd=%0d wd=%h want 1 7 77",
                             wr, rd, wd);
                end
            end else begin
                n_cmp++;
                if ({wr, rd, wd} !== {1'b1, 5'd2, 32'h200 + 32'(c)}) begin
                    n_bad++;
                    $display("FAIL starve_alu c=%0d wr=%b rd=%0d wd=%h want 1 2 %h",
                             c, wr, rd, wd, 32'h200 + 32'(c));
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        alu_valid  = 1'b1;
        alu_rd     = 5'd2;
        alu_data   = 32'h300;
        load_valid = 1'b1;
        load_rd    = 5'd8;
        load_data  = 32'h88;
        step();
        load_rd    = 5'd9;
        load_data  = 32'h99;
        step();
        load_valid = 1'b0;
        q_rs       = 5'd9;
        #1;
        n_cmp++;
        if (q_hit !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_qhit q_hit=%b want 1", q_hit);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({wr, rd, wd} !== 38'd0) begin
            n_bad++;
            $display("FAIL mid_rst_out wr=%b rd=%0d wd=%h want 0", wr, rd, wd);
        end
        n_cmp++;
        if ({load_ready, alu_ready, q_hit} !== 3'b110) begin
            n_bad++;
            $display("FAIL mid_rst_hs lr=%b ar=%b qh=%b want 1 1 0",
                     load_ready, alu_ready, q_hit);
        end
        step();
        idle_inputs();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            n_cmp++;
            if (wr !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_nowr c=%0d wr=%b rd=%0d want 0", c, wr, rd);
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #2;
        test_reset();
        test_alu_path();
        test_load_query();
        test_x0_drop();
        test_full_fifo();
        test_starvation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Write-back stage placed directly upstream of `register_file`. It merges two result sources, single-cycle ALU results and load-return data, onto the register file's single write port (`rd`, `wr`, `wd`). Load returns are buffered in a small FIFO while the ALU holds the port. A starvation guard and a pending-destination query port support hazard/stall logic in decode.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): data path width, taken from `defs.vh`.
- `DEPTH`, default 4: load FIFO entries; must be a power of two, ≥2.
- `STARVE_LIMIT`, default 8: maximum consecutive cycles the FIFO head may be denied the port.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `alu_valid`  in  1  ALU result present.
- `alu_ready`  out  1  ALU result accepted this cycle when `alu_valid` is also high.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  DATA_WIDTH  ALU result.
- `load_valid`  in  1  load return present.
- `load_ready`  out  1  low when the FIFO is full.
- `load_rd`  in  5  load destination register.
- `load_data`  in  DATA_WIDTH  load data.
- `q_rs`  in  5  register index queried by decode.
- `q_hit`  out  1  combinational; high when any valid FIFO entry has `rd == q_rs` and `q_rs != 0`.
- `rd`  out  5  register-file write address (registered).
- `wr`  out  1  register-file write enable (registered).
- `wd`  out  DATA_WIDTH  register-file write data (registered).

## Operation
- Load push: occurs when `load_valid && load_ready`. An entry with `load_rd == 0` completes the handshake but is discarded, not stored.
- `load_ready = (count != DEPTH)`, derived from registered count only. A full FIFO rejects a push even in a cycle where it pops.
- Port selection each cycle, in priority order:
  1. Forced drain: `wait_cnt == STARVE_LIMIT` and FIFO non-empty. FIFO head wins, `alu_ready = 0`.
  2. Otherwise `alu_ready = 1`. If `alu_valid` and `alu_rd != 0`, the ALU wins.
  3. Otherwise, if the FIFO is non-empty, the FIFO head pops and wins.
  4. Otherwise no write.
- An ALU result with `alu_rd == 0` is accepted and dropped. The slot passes to the FIFO head in the same cycle.
- Output register: the winner's `rd`/`wd` is captured with `wr = 1`. With no winner, `wr = 0` and `rd`/`wd` hold their previous values.
- `wait_cnt`, width `clog2(STARVE_LIMIT+1)`:
  - clears when the FIFO is empty or the head pops;
  - otherwise increments by 1 each cycle the non-empty head is denied;
  - saturates at `STARVE_LIMIT`.
- FIFO implementation:
  - circular buffer with `log2(DEPTH)`-bit read/write pointers that wrap modulo DEPTH;
  - `count` is 0..DEPTH;
  - simultaneous push and pop leave `count` unchanged.
- `q_hit` scans all valid entries, including the head in the cycle it pops. Pushes become visible to `q_hit` the cycle after the push.

## Timing
- Reset (asynchronous assert, synchronous-effect deassert): `wr=0`, `rd=0`, `wd=0`, FIFO empty, pointers 0, `wait_cnt=0`. Consequently `load_ready=1`, `alu_ready=1`, `q_hit=0`.
- ALU latency: accepted in cycle N, so `wr`/`rd`/`wd` are valid in cycle N+1.
- Load latency, minimum: pushed in cycle N, head selected in N+1, `wr` high in N+2. No bypass path exists.
- Port throughput: at most one register write per cycle. ALU and FIFO never write in the same cycle.
- Starvation bound: a non-empty head waits at most STARVE_LIMIT denied cycles. The ALU is then stalled for exactly one cycle.
- Reset asserted mid-operation: all FIFO contents are lost and outputs return to reset values immediately, without waiting for `clk`.

## Test plan
- Reset: hold `rst_n=0` with random inputs -> `wr=0`, `rd=0`, `wd=0`, `load_ready=1`, `alu_ready=1`, `q_hit=0`.
- ALU path: `alu_rd=6`, `alu_data=0xAAAAAAAA` for one cycle -> next cycle `wr=1`, `rd=6`, `wd=0xAAAAAAAA`; the following cycle `wr=0`.
- Load path plus query: idle ALU, `load_rd=3`, `load_data=0x55555555` in cycle N -> `q_hit=1` for `q_rs=3` in N+1; `wr=1`, `rd=3`, `wd=0x55555555` in N+2.
- x0 drop: ALU `rd=0` in the same cycle FIFO holds `rd=5`, `0x1234` -> next cycle `wr=1`, `rd=5`, `wd=0x1234`. A load with `rd=0` -> `count` unchanged, no write.
- Full FIFO: ALU valid with `rd=1` continuously for 4 cycles while 5 loads are offered -> `load_ready=0` after 4 pushes; 5th load stalls until the first pop; FIFO writes appear in push order.
- Starvation, then reset: ALU valid continuously plus one load -> after 8 denied cycles `alu_ready=0` for one cycle and the load writes. Repeat, and assert `rst_n=0` while the FIFO holds 2 entries -> FIFO empties, no subsequent load writes appear.
